// File: rtl/disp_pkg.sv
// Shared widths and types for the seven-segment scan controller.
package disp_pkg;
    localparam int DIGIT_W = 4;
    localparam int IDX_W   = 3;

    typedef logic [DIGIT_W-1:0] nibble_t;
    typedef logic [31:0]        disp_word_t;
endpackage

// File: rtl/scan_prescaler.sv
// Refresh prescaler: one-cycle tick every DIV enabled clocks.
module scan_prescaler #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan controller: steps the digit index, double-buffers the word
// and presents the registered nibble/blank pair for each slot.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  disp_word_t       value,
    output logic [IDX_W-1:0] dig_sel,
    output nibble_t          nibble,
    output logic             digit_blank,
    output logic             frame_done
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [63:0] USED_W = (64'd1 << (4 * NUM_DIGITS)) - 64'd1;
    localparam disp_word_t  USED   = USED_W[31:0];

    logic             tick;
    logic             wrap;
    logic [IDX_W-1:0] nxt_idx;
    disp_word_t       active;
    disp_word_t       pending;
    logic             pend_valid;
    disp_word_t       nxt_active;
    disp_word_t       upper;
    nibble_t          nxt_nib;
    logic             nxt_blank;

    scan_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .tick  (tick)
    );

    // Work out what the next slot shows, including a same-edge buffer swap.
    always_comb begin
        wrap       = tick && (dig_sel == LAST);
        nxt_idx    = wrap ? '0 : dig_sel + IDX_W'(1);
        nxt_active = active;
        if (wrap) begin
            if (load) begin
                nxt_active = value;
            end else if (pend_valid) begin
                nxt_active = pending;
            end
        end
        upper     = (nxt_active & USED) >> {nxt_idx, 2'b00};
        nxt_nib   = nibble_t'(upper);
        nxt_blank = 1'b0;
        if (LZ_BLANK && (nxt_idx != '0)) begin
            nxt_blank = (upper == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_sel     <= '0;
            nibble      <= '0;
            digit_blank <= 1'b0;
            frame_done  <= 1'b0;
            active      <= '0;
            pending     <= '0;
            pend_valid  <= 1'b0;
        end else begin
            frame_done <= wrap;
            active     <= nxt_active;
            if (tick) begin
                dig_sel     <= nxt_idx;
                nibble      <= nxt_nib;
                digit_blank <= nxt_blank;
            end
            if (wrap) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pending    <= value;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (8 digits, 4 clocks per slot).
module tb_display_scan_ctrl;
    localparam int ND  = 8;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [2:0]  dig_sel;
    logic [3:0]  nibble;
    logic        digit_blank;
    logic        frame_done;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int          m_cnt, m_idx;
    logic [31:0] m_active, m_pend;
    bit          m_pv;
    int          e_idx;
    logic [3:0]  e_nib;
    bit          e_blank, e_fd;
    int          fd_count;

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dig_sel     (dig_sel),
        .nibble      (nibble),
        .digit_blank (digit_blank),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_active = '0; m_pend = '0; m_pv = 0;
        e_idx = 0; e_nib = '0; e_blank = 0; e_fd = 0;
    endtask

    task automatic show_slot();
        logic [31:0] up;
        up = m_active >> (4 * m_idx);
        e_idx = m_idx;
        e_nib = up[3:0];
        e_blank = (m_idx > 0) && (up == 0);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dig_sel"}, 32'(dig_sel), 32'(e_idx));
        chk({tag, ".nibble"}, 32'(nibble), 32'(e_nib));
        chk({tag, ".blank"}, 32'(digit_blank), 32'(e_blank));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    // One clock with the given inputs, then update model and check.
    task automatic cyc(input bit en, input bit ld, input logic [31:0] v,
                       input string tag);
        bit tk, wr;
        enable = en; load = ld; value = v;
        @(posedge clk);
        tk = en && (m_cnt == DIV - 1);
        if (en) m_cnt = (m_cnt + 1) % DIV;
        wr = tk && (m_idx == ND - 1);
        if (wr) begin
            if (ld) m_active = v;
            else if (m_pv) m_active = m_pend;
            m_pv = 0;
        end else if (ld) begin
            m_pend = v; m_pv = 1;
        end
        if (tk) begin
            m_idx = (m_idx + 1) % ND;
            show_slot();
        end
        e_fd = wr;
        if (wr) fd_count++;
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, tag);
    endtask

    task automatic run_to(input int idx, input int cnt, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (m_idx == idx && m_cnt == cnt) return;
            cyc(1, 0, '0, tag);
        end
        chk({tag, ".timeout"}, 32'(1), 32'(0));
    endtask

    initial begin
        logic [31:0] rv;
        bit ren, rld;
        model_reset();
        reset = 1'b1;
        #2;
        check_all("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: free running scan, one frame_done per 32 clocks
        fd_count = 0;
        run(64, "scan");
        chk("frame_count", 32'(fd_count), 32'd2);

        // 2: mid-frame load, kept until wrap
        run_to(3, 1, "pre2");
        cyc(1, 1, 32'h0000_1234, "load1234");
        run(70, "show1234");

        // 3: zero word
        run_to(2, 0, "pre3");
        cyc(1, 1, 32'h0, "load0");
        run(70, "show0");

        // 4: last of two loads wins, then load on the wrap tick
        run_to(1, 2, "pre4");
        cyc(1, 1, 32'hA0, "loadA0");
        run(5, "mid4");
        cyc(1, 1, 32'hB0, "loadB0");
        run(70, "showB0");
        run_to(ND - 1, DIV - 1, "prewrap");
        cyc(1, 1, 32'h0000_0F07, "loadwrap");
        chk("wrap_nib", 32'(nibble), 32'h7);
        run(40, "postwrap");

        // 5: freeze at digit 5
        run_to(5, 1, "pre5");
        fd_count = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, '0, "frozen");
        chk("frozen_sel", 32'(dig_sel), 32'd5);
        chk("frozen_fd", 32'(fd_count), 32'd0);
        run(40, "resume");

        // 6: asynchronous reset mid-frame at digit 6
        cyc(1, 1, 32'h8765_4321, "load6");
        run_to(6, 2, "pre6");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        run(40, "after_rst");

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            ren = ($urandom_range(0, 9) != 0);
            rld = ($urandom_range(0, 19) == 0);
            rv = $urandom;
            rv = rv >> (4 * $urandom_range(0, 7));
            cyc(ren, rld, rv, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
